// File: rtl/cape_decoder.sv
// -----------------------------------------------------------------------------
// cape_decoder
//   Stochastic-to-binary decoder for CAPE / cape_ET SNG bitstreams.
//   Each lane counts weighted 1s over one generation window. The window is
//   closed by the SNG's done pulse. The decoded values and the window length
//   in bit_valid cycles are presented through a valid/ready handshake.
//
// Parameters
//   WIDTH       binary precision; full-length window = 2**WIDTH bits
//   NUM_INPUTS  number of independent decoded lanes
//   WT_W        width of bit_wt
//
// Ports
//   clk         clock, posedge
//   rst_n       asynchronous active-low reset
//   clear       synchronous clear of accumulators, window count, ovr, out_valid
//   bit_valid   Xs / bit_wt carry a bit this cycle
//   Xs          stochastic bits, one per lane
//   bit_wt      log2 of the cycles this bit stands for (ET bypass depth)
//   done_in     SNG done pulse: the window ended on the previous bit
//   out_ready   consumer accepts the presented result
//   out_valid   Bys / win_cycles hold a completed window
//   Bys         decoded values per lane
//   win_cycles  bit_valid cycles in the reported window
//   ovr         sticky: a completed window overwrote an unaccepted one
//
// Configuration
//   CAPE_DEC_ET_WEIGHT_EN defined   : each 1 adds 1 << min(bit_wt, WIDTH)
//   CAPE_DEC_ET_WEIGHT_EN undefined : bit_wt ignored, each 1 adds exactly 1
//   The port list is identical in both builds.
// -----------------------------------------------------------------------------
module cape_decoder #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 1,
  parameter int WT_W       = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  bit_valid,
  input  logic [NUM_INPUTS-1:0] Xs,
  input  logic [WT_W-1:0]       bit_wt,
  input  logic                  done_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      Bys [NUM_INPUTS-1:0],
  output logic [WIDTH:0]        win_cycles,
  output logic                  ovr
);

  // 2**WIDTH: the saturation ceiling of accumulators and the window counter
  localparam logic [WIDTH:0] FULL_SCALE = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE        = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e                         state_q;
  logic                           out_valid_q;
  logic                           ovr_q;
  logic [WIDTH:0]                 win_cycles_q;
  logic [WIDTH:0]                 cyc_cnt_q;
  logic [WIDTH:0]                 cyc_cnt_d;
  logic [NUM_INPUTS-1:0][WIDTH:0] acc_q;
  logic [NUM_INPUTS-1:0][WIDTH:0] acc_d;    // running window plus this bit
  logic [NUM_INPUTS-1:0][WIDTH:0] first_d;  // this bit alone, starts a new window
  logic [NUM_INPUTS-1:0][WIDTH-1:0] bys_q;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] bys_d;
  logic [WIDTH:0]                 wt_val;

  // Add with a ceiling of 2**WIDTH; the extra sum bit catches the carry.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH:0] a,
                                             input logic [WIDTH:0] b);
    logic [WIDTH+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, FULL_SCALE}) return FULL_SCALE;
    return s[WIDTH:0];
  endfunction

`ifdef CAPE_DEC_ET_WEIGHT_EN
  // One-hot weight; depths beyond WIDTH clamp to a full window's worth.
  always_comb begin
    wt_val = '0;
    if (bit_wt >= WT_W'(WIDTH)) wt_val[WIDTH] = 1'b1;
    else                        wt_val[bit_wt] = 1'b1;
  end
`else
  logic unused_bit_wt;
  assign unused_bit_wt = ^bit_wt;
  assign wt_val        = ONE;
`endif

  assign cyc_cnt_d = sat_add(cyc_cnt_q, ONE);

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    assign acc_d[gi]   = sat_add(acc_q[gi], Xs[gi] ? wt_val : '0);
    assign first_d[gi] = (bit_valid && Xs[gi]) ? wt_val : '0;
    // A saturated accumulator holds exactly 2**WIDTH, reported as all ones.
    assign bys_d[gi]   = acc_q[gi][WIDTH] ? {WIDTH{1'b1}} : acc_q[gi][WIDTH-1:0];
    assign Bys[gi]     = bys_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      out_valid_q  <= 1'b0;
      ovr_q        <= 1'b0;
      win_cycles_q <= '0;
      cyc_cnt_q    <= '0;
      acc_q        <= '0;
      bys_q        <= '0;
    end else if (clear) begin
      state_q      <= S_EMPTY;
      out_valid_q  <= 1'b0;
      ovr_q        <= 1'b0;
      win_cycles_q <= '0;
      cyc_cnt_q    <= '0;
      acc_q        <= '0;
      bys_q        <= '0;
    end else if (done_in) begin
      // Close the window. A bit arriving with done_in belongs to the next one.
      bys_q        <= bys_d;
      win_cycles_q <= cyc_cnt_q;
      acc_q        <= first_d;
      cyc_cnt_q    <= bit_valid ? ONE : '0;
      state_q      <= S_FULL;
      out_valid_q  <= 1'b1;
      if (state_q == S_FULL && !out_ready) ovr_q <= 1'b1;
    end else begin
      if (bit_valid) begin
        acc_q     <= acc_d;
        cyc_cnt_q <= cyc_cnt_d;
      end
      if (state_q == S_FULL && out_ready) begin
        state_q     <= S_EMPTY;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign win_cycles = win_cycles_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_cape_decoder.sv
// -----------------------------------------------------------------------------
// tb_cape_decoder
//   Directed scenarios with literal expectations, then a randomized phase.
//   A window-level integer model runs alongside and is compared with the DUT
//   outputs on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_cape_decoder;

  localparam int W   = 8;
  localparam int NI  = 2;
  localparam int WTW = $clog2(W + 1);
  localparam int FS  = 1 << W;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic           bit_valid;
  logic [NI-1:0]  xs;
  logic [WTW-1:0] bit_wt;
  logic           done_in;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   bys [NI-1:0];
  logic [W:0]     win_cycles;
  logic           ovr;

  int total = 0;
  int bad   = 0;

  cape_decoder #(.WIDTH(W), .NUM_INPUTS(NI), .WT_W(WTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_valid  (bit_valid),
    .Xs         (xs),
    .bit_wt     (bit_wt),
    .done_in    (done_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .Bys        (bys),
    .win_cycles (win_cycles),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic int wgt(input int w);
`ifdef CAPE_DEC_ET_WEIGHT_EN
    return 1 << ((w > W) ? W : w);
`else
    int unused_w;
    unused_w = w;
    return 1;
`endif
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  int m_acc [NI];
  int m_bys [NI];
  int m_cyc, m_win, m_valid, m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NI; i++) begin
        m_acc[i] <= 0;
        m_bys[i] <= 0;
      end
      m_cyc   <= 0;
      m_win   <= 0;
      m_valid <= 0;
      m_ovr   <= 0;
    end else if (done_in) begin
      for (int i = 0; i < NI; i++) begin
        m_bys[i] <= imin(m_acc[i], FS - 1);
        m_acc[i] <= (bit_valid && xs[i]) ? wgt(int'(bit_wt)) : 0;
      end
      m_win <= m_cyc;
      m_cyc <= bit_valid ? 1 : 0;
      if (m_valid != 0 && !out_ready) m_ovr <= 1;
      m_valid <= 1;
    end else begin
      if (bit_valid) begin
        for (int i = 0; i < NI; i++)
          m_acc[i] <= imin(m_acc[i] + (xs[i] ? wgt(int'(bit_wt)) : 0), FS);
        m_cyc <= imin(m_cyc + 1, FS);
      end
      if (out_ready) m_valid <= 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      check($sformatf("cyc_bys%0d", i), int'(bys[i]), m_bys[i]);
    check("cyc_win", int'(win_cycles), m_win);
    check("cyc_valid", int'(out_valid), m_valid);
    check("cyc_ovr", int'(ovr), m_ovr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic bv, input logic [NI-1:0] x, input logic [WTW-1:0] w,
                      input logic d, input logic rdy);
    bit_valid = bv;
    xs        = x;
    bit_wt    = w;
    done_in   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // n valid bits on lane 0, the first n_one of them ones; lane 1 random
  task automatic bits(input int n, input int n_one, input logic [WTW-1:0] w, input logic rdy);
    logic [NI-1:0] x;
    for (int c = 0; c < n; c++) begin
      x    = '0;
      x[0] = (c < n_one);
      x[1] = 1'($urandom_range(0, 1));
      step(1'b1, x, w, 1'b0, rdy);
    end
  endtask

  task automatic close_window(input logic rdy);
    step(1'b0, '0, '0, 1'b1, rdy);
  endtask

  task automatic consume();
    step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NI-1:0] x;
    int            t3_exp;

    rst_n = 1'b0; clear = 1'b0; bit_valid = 1'b0; xs = '0;
    bit_wt = '0; done_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_win", int'(win_cycles), 0);
    check("rst_bys", int'(bys[0]), 0);
    rst_n = 1'b1;

    // T1: 100 ones in a 256-bit window
    bits(256, 100, '0, 1'b0);
    check("t1_pre_valid", int'(out_valid), 0);
    close_window(1'b0);
    check("t1_valid", int'(out_valid), 1);
    check("t1_bys", int'(bys[0]), 100);
    check("t1_win", int'(win_cycles), 256);
    consume();
    check("t1_consumed", int'(out_valid), 0);

    // T2: all ones saturates
    bits(256, 256, '0, 1'b0);
    close_window(1'b0);
    check("t2_bys", int'(bys[0]), 255);
    check("t2_win", int'(win_cycles), 256);
    consume();

    // T2b: window longer than 2**W, cycle count saturates
    bits(300, 0, '0, 1'b0);
    close_window(1'b1);
    check("t2b_bys", int'(bys[0]), 0);
    check("t2b_win", int'(win_cycles), 256);
    consume();

    // T3: weighted bits
    bits(32, 12, 4'd3, 1'b0);
    close_window(1'b0);
`ifdef CAPE_DEC_ET_WEIGHT_EN
    t3_exp = 96;
`else
    t3_exp = 12;
`endif
    check("t3_bys", int'(bys[0]), t3_exp);
    check("t3_win", int'(win_cycles), 32);
    consume();

    // T4: overrun, then clear
    bits(40, 40, '0, 1'b0);
    close_window(1'b0);
    check("t4_first_bys", int'(bys[0]), 40);
    check("t4_first_ovr", int'(ovr), 0);
    bits(70, 70, '0, 1'b0);
    close_window(1'b0);
    check("t4_bys", int'(bys[0]), 70);
    check("t4_win", int'(win_cycles), 70);
    check("t4_ovr", int'(ovr), 1);
    clear = 1'b1;
    step(1'b1, '1, '0, 1'b1, 1'b0);
    clear = 1'b0;
    check("t4_clr_ovr", int'(ovr), 0);
    check("t4_clr_valid", int'(out_valid), 0);
    check("t4_clr_bys", int'(bys[0]), 0);

    // T5: bit coincident with done starts the next window
    bits(5, 5, '0, 1'b0);
    x = 2'b01;
    step(1'b1, x, '0, 1'b1, 1'b0);
    check("t5_first_bys", int'(bys[0]), 5);
    check("t5_first_win", int'(win_cycles), 5);
    bits(9, 9, '0, 1'b0);
    close_window(1'b1);
    check("t5_bys", int'(bys[0]), 10);
    check("t5_win", int'(win_cycles), 10);
    check("t5_ovr", int'(ovr), 0);
    check("t5_valid", int'(out_valid), 1);

    // T6: reset mid-window discards the partial window
    bits(50, 50, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_bys", int'(bys[0]), 0);
    check("t6_rst_win", int'(win_cycles), 0);
    check("t6_rst_ovr", int'(ovr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bits(20, 20, '0, 1'b0);
    close_window(1'b1);
    check("t6_bys", int'(bys[0]), 20);
    check("t6_win", int'(win_cycles), 20);
    consume();

    // Randomized phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      x     = NI'($urandom);
      clear = ($urandom_range(0, 499) == 0);
      step(($urandom_range(0, 3) != 0), x, WTW'($urandom_range(0, 15)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end
    clear = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
